// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the memory
// stage (DM). Each access is one req/ack exchange with a variable-latency
// memory; a watchdog completes accesses that are never acknowledged.
//
// Handshake: a requester raises *_req with its fields and holds them until
// its *_ready pulses for one cycle. Toward memory, mem_req and all mem_*
// fields are held stable until the cycle after mem_ack. mem_ack is honoured
// only while an access is outstanding.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_ready,
  input  logic                      dm_req,
  input  logic                      dm_we,
  input  logic [ADDRESS_WIDTH-1:0]  dm_addr,
  input  logic [DATA_WIDTH-1:0]     dm_wdata,
  input  logic [DATA_WIDTH/8-1:0]   dm_wstrb,
  output logic [DATA_WIDTH-1:0]     dm_rdata,
  output logic                      dm_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      stall_mem,
  output logic                      bus_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Last BUSY cycle in which an ack can still arrive; with no ack by then
  // the access is forced to complete.
  localparam logic [7:0] WATCHDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] watchdog;
  logic       timeout;

  assign timeout = (watchdog == WATCHDOG_LAST);

  // Freeze the pipeline while any request is pending and not yet completing.
  assign stall_mem = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  // Arbitration FSM: DM has fixed priority, completion goes through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      watchdog  <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
            watchdog  <= 8'd0;
            state     <= BUSY_D;
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wstrb <= {STRB_WIDTH{1'b0}};
            watchdog  <= 8'd0;
            state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || timeout) begin
            // An ack in the last watchdog cycle still wins over the timeout.
            if (state == BUSY_I) begin
              if_rdata <= mem_ack ? mem_rdata : '0;
              if_ready <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : '0;
              dm_ready <= 1'b1;
            end
            bus_err <= ~mem_ack;
            mem_req <= 1'b0;
            state   <= RESP;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder with planned latencies, a
// driver issuing IF/DM/collision transactions, and a monitor popping the
// expected completion queue on every ready pulse.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [SW-1:0] dm_wstrb;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_mem;
  logic          bus_err;

  mem_port_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wstrb (dm_wstrb),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_mem(stall_mem),
    .bus_err  (bus_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit            dm;
    bit            store;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    bit            is_dm;
  } mreq_t;

  rsp_t  rsp_q[$];   // expected completions, in service order
  mreq_t mreq_q[$];  // expected memory requests, in service order
  int    lat_q[$];   // ack latency per memory request, -1 = never ack

  int            exp_ready_cyc = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_dm = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Contents the modelled memory returns for a read of address a.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bit    active;
    int    lat;
    int    rise;
    mreq_t cur;
    active    = 1'b0;
    lat       = -1;
    rise      = 0;
    cur       = '{default: '0};
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (active && !mem_req) begin
        // Access ended without an ack (timeout or reset): send a late ack.
        active    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else if (!active && mem_req) begin
        active = 1'b1;
        rise   = cyc;
        if (mreq_q.size() == 0 || lat_q.size() == 0) begin
          fail("unexpected_mem_req");
          lat = -1;
          cur = '{default: '0};
        end else begin
          cur = mreq_q.pop_front();
          lat = lat_q.pop_front();
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wstrb", mem_wstrb, cur.strb);
          if (cur.is_dm) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        exp_ready_cyc = (lat >= 0) ? rise + lat + 1 : rise + TO;
      end else if (!active && !mem_req) begin
        // Stray acks while nothing is outstanding must be ignored.
        if ($urandom_range(0, 7) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
      if (active) begin
        if (cyc > rise) begin
          chk("mem_addr_hold", mem_addr, cur.addr);
          chk("mem_we_hold", mem_we, cur.we);
          if (cur.is_dm) chk("mem_wdata_hold", mem_wdata, cur.wdata);
        end
        if (lat >= 0 && cyc == rise + lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          active    = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_ready || dm_ready) begin
          chk("ready_onehot", int'(if_ready) + int'(dm_ready), 1);
          if (rsp_q.size() == 0) begin
            fail("spurious_ready");
          end else begin
            e = rsp_q.pop_front();
            chk("ready_port_dm", dm_ready, e.dm);
            chk("bus_err", bus_err, e.err);
            chk("ready_cycle", cyc, exp_ready_cyc);
            if (!e.dm) last_if = e.rdata;
            else if (!e.store) last_dm = e.rdata;
            chk("if_rdata", if_rdata, last_if);
            chk("dm_rdata", dm_rdata, last_dm);
          end
        end else begin
          chk("bus_err_idle", bus_err, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input bit use_if, input bit use_dm, input logic [AW-1:0] ia,
                        input int ilat, input bit we, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic [SW-1:0] st, input int dlat,
                        output int t0, output int if_done, output int dm_done);
    rsp_t  r;
    mreq_t m;
    @(posedge clk);
    #1;
    t0      = cyc;
    if_done = -1;
    dm_done = -1;
    // DM is older, so it is served first when both request together.
    if (use_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = da; dm_wdata = wd; dm_wstrb = st;
      m = '{we: we, addr: da, wdata: wd, strb: st, is_dm: 1'b1};
      r = '{dm: 1'b1, store: we, rdata: (dlat < 0) ? '0 : mem_word(da), err: (dlat < 0)};
      mreq_q.push_back(m);
      rsp_q.push_back(r);
      lat_q.push_back(dlat);
    end
    if (use_if) begin
      if_req = 1'b1; if_addr = ia;
      m = '{we: 1'b0, addr: ia, wdata: '0, strb: '0, is_dm: 1'b0};
      r = '{dm: 1'b0, store: 1'b0, rdata: (ilat < 0) ? '0 : mem_word(ia), err: (ilat < 0)};
      mreq_q.push_back(m);
      rsp_q.push_back(r);
      lat_q.push_back(ilat);
    end
    for (int k = 0; k < 400 && (if_req || dm_req); k++) begin
      @(negedge clk);
      chk("stall_mem", stall_mem, (if_req && !if_ready) || (dm_req && !dm_ready));
      if (dm_req && dm_ready) begin dm_done = cyc; dm_req = 1'b0; end
      if (if_req && if_ready) begin if_done = cyc; if_req = 1'b0; end
    end
    if (if_req || dm_req) begin
      fail("txn_no_ready");
      if_req = 1'b0;
      dm_req = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, ifd, dmd, kind, ilat, dlat, r;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall_mem, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch only, ack one cycle after mem_req.
    do_txn(1, 0, 32'h100, 1, 0, '0, '0, '0, 0, t0, ifd, dmd);
    chk("fetch_ready_at", ifd, t0 + 3);

    // Collision: DM load first, IF afterwards, both with ack latency 2.
    do_txn(1, 1, 32'h180, 2, 0, 32'h200, 32'h1234_5678, 4'h3, 2, t0, ifd, dmd);
    chk("collide_dm_ready_at", dmd, t0 + 4);
    chk("collide_if_ready_at", ifd, t0 + 9);

    // Store: dm_rdata keeps the previous load value.
    do_txn(0, 1, '0, 0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3, t0, ifd, dmd);
    chk("store_ready_at", dmd, t0 + 5);

    // Load that is never acknowledged.
    do_txn(0, 1, '0, 0, 0, 32'h300, '0, '0, -1, t0, ifd, dmd);
    chk("timeout_ready_at", dmd, t0 + 1 + TO);

    // Store that times out, then fetch timeout.
    do_txn(0, 1, '0, 0, 1, 32'h44, 32'hCAFE_F00D, 4'h5, -1, t0, ifd, dmd);
    do_txn(1, 0, 32'h104, -1, 0, '0, '0, '0, 0, t0, ifd, dmd);
    chk("if_timeout_ready_at", ifd, t0 + 1 + TO);

    // Variable latencies 1, 5, 17.
    foreach (lat_q[i]) r = i;
    do_txn(1, 0, 32'h108, 1, 0, '0, '0, '0, 0, t0, ifd, dmd);
    chk("lat1_ready_at", ifd, t0 + 3);
    do_txn(1, 0, 32'h10C, 5, 0, '0, '0, '0, 0, t0, ifd, dmd);
    chk("lat5_ready_at", ifd, t0 + 7);
    do_txn(0, 1, '0, 0, 0, 32'h210, '0, '0, 17, t0, ifd, dmd);
    chk("lat17_ready_at", dmd, t0 + 19);

    // Randomized mix.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      ilat = (r == 0) ? -1 : (r == 1) ? 17 : $urandom_range(0, 6);
      r    = $urandom_range(0, 9);
      dlat = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 6);
      do_txn(kind != 1, kind != 0, {$urandom_range(0, 32'h3FFF), 2'b00}, ilat,
             1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00},
             $urandom, 4'($urandom_range(0, 15)), dlat, t0, ifd, dmd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of a DM load: no ready, outputs back to reset.
    @(posedge clk);
    #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_wdata = 32'h55; dm_wstrb = 4'h1;
    mreq_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h55, strb: 4'h1, is_dm: 1'b1});
    lat_q.push_back(-1);
    t0 = cyc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    dm_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_dm_ready", dm_ready, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_dm_rdata", dm_rdata, 0);
    chk("midrst_bus_err", bus_err, 0);
    last_if = '0;
    last_dm = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", rsp_q.size() + mreq_q.size() + lat_q.size(), 0);

    // One more access after the mid-access reset.
    do_txn(1, 0, 32'h600, 2, 0, '0, '0, '0, 0, t0, ifd, dmd);
    chk("post_rst_ready_at", ifd, t0 + 4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-port memory between the instruction-fetch stage (IF) and the memory stage (DM) of the 5-stage pipeline. It sequences each access with a req/ack handshake toward a variable-latency memory. It raises `stall_mem` so the pipeline hazard logic freezes the pipeline while any access is outstanding. A watchdog completes accesses the memory never acknowledges.

## Interface
- `ADDRESS_WIDTH`, 32: width of all address buses.
- `DATA_WIDTH`, 32: width of all data buses; strobe width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `mem_ack` before forced completion. Range 1..255; counter is 8 bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ready`.
- `if_addr`  in  ADDRESS_WIDTH  fetch address.
- `if_rdata`  out  DATA_WIDTH  fetched word; valid while `if_ready`=1, then held.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `dm_req`  in  1  data request; held with its fields until `dm_ready`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDRESS_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  store data.
- `dm_wstrb`  in  DATA_WIDTH/8  store byte enables.
- `dm_rdata`  out  DATA_WIDTH  load data; valid while `dm_ready`=1, then held.
- `dm_ready`  out  1  one-cycle completion pulse for data.
- `mem_req`  out  1  memory request; registered.
- `mem_we`  out  1  memory write enable; registered.
- `mem_addr`  out  ADDRESS_WIDTH  memory address; registered.
- `mem_wdata`  out  DATA_WIDTH  memory write data; registered.
- `mem_wstrb`  out  DATA_WIDTH/8  memory byte enables; registered.
- `mem_rdata`  in  DATA_WIDTH  memory read data; sampled in the `mem_ack` cycle.
- `mem_ack`  in  1  single-cycle acknowledge from memory.
- `stall_mem`  out  1  pipeline freeze request to the hazard unit; combinational.
- `bus_err`  out  1  timeout flag; pulses together with the affected ready.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE transitions:
  - `dm_req`=1: latch DM fields into the `mem_*` registers, `mem_req`<=1, go to BUSY_D.
  - Otherwise, `if_req`=1: latch `if_addr`, `mem_we`<=0, `mem_wstrb`<=0, `mem_req`<=1, go to BUSY_I.
  - DM has fixed priority because it belongs to the older instruction. IF cannot starve: the pipeline is frozen, so `dm_req` drops once served.
- BUSY_x, `mem_ack`=1:
  - Capture `mem_rdata` into `if_rdata` (BUSY_I) or `dm_rdata` (BUSY_D, loads only).
  - `mem_req`<=0, go to RESP.
  - Stores leave `dm_rdata` unchanged.
- BUSY_x, watchdog reaches `TIMEOUT_CYCLES` without `mem_ack`:
  - Captured data <= 0, `bus_err`<=1, `mem_req`<=0, go to RESP.
- RESP: the served requester's ready is 1 for exactly this cycle; go to IDLE. Requests are not sampled in RESP.
- Watchdog: clears on entry to BUSY_x and increments each BUSY cycle without ack.
- `stall_mem` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`).
- `mem_ack` in IDLE or RESP is ignored and leaves no state or output change.
- `mem_*` outputs hold stable from the cycle `mem_req` rises until the cycle after ack.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `if_rdata`, `dm_rdata` = 0.
  - `if_ready`, `dm_ready`, `bus_err` = 0.
  - watchdog = 0.
  - `stall_mem` follows its equation.
- Request sampled in IDLE at cycle T → `mem_req`=1 at T+1.
- Ack at cycle A (A ≥ T+1) → ready=1 at A+1, back in IDLE at A+2, next `mem_req` no earlier than A+3.
- Minimum access: 3 cycles from request to ready; throughput one access per 3 cycles.
- Timeout with no ack: ready and `bus_err` at T+1+`TIMEOUT_CYCLES`.
- Simultaneous `if_req` and `dm_req` in IDLE: DM served first; IF is served in the IDLE cycle after DM's RESP if still requested.
- Reset asserted mid-access: the outstanding access is abandoned, `mem_req`=0 next cycle, and no ready pulse is issued. Late acks are then ignored.

## Test plan
- Fetch only: `if_addr`=0x100, memory acks 1 cycle after `mem_req` with 0x00000013 → `mem_req`=1 at T+1; `if_ready`=1 with `if_rdata`=0x13 at T+3; `stall_mem`=1 for T..T+2.
- Collision: `if_req` and `dm_req` (load 0x200) both rise in cycle T; ack latency 2 → DM first (`mem_addr`=0x200, `mem_we`=0); `dm_ready` at T+4; IF `mem_req` at T+6.
- Store: `dm_we`=1, addr 0x40, wdata 0xDEADBEEF, wstrb 0xF → `mem_we`=1 and fields stable until ack; `dm_ready` pulses; `dm_rdata` unchanged.
- Timeout: `TIMEOUT_CYCLES`=4, load with no ack → `dm_ready`=1, `bus_err`=1, `dm_rdata`=0 at T+5; a late `mem_ack` is ignored.
- Reset mid-access: `rst` in BUSY_D → `mem_req`=0 next cycle, all outputs at reset values, no `dm_ready`.
- Variable latency: acks at 1, 5 and 17 cycles → each ready exactly 1 cycle after its ack; no double pulses.
